// File: rtl/pll_lock_manager.sv
// rtl/pll_lock_manager.sv - PLL reset sequencing, lock qualification and staggered domain reset release
module pll_lock_manager #(
    parameter int NUM_CLOCKS    = 4,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  force_relock,
    output logic                  pll_rst,
    output logic [NUM_CLOCKS-1:0] rst_out,
    output logic                  ready,
    output logic                  fault,
    output logic [CNT_W-1:0]      lock_loss_count
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT);
    localparam int ST_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int SG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES);
    localparam logic [RC_W-1:0] RC_FIRST = RC_W'(1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_LAST  = ST_W'(STABLE_CYCLES - 1);
    localparam logic [SG_W-1:0] SG_LAST  = SG_W'(STAGGER - 1);
    localparam logic [RT_W-1:0] RT_MAX   = RT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_locked_s;
    logic                  r_pll_rst;
    logic [NUM_CLOCKS-1:0] r_rst_out;
    logic                  r_ready;
    logic                  r_fault;
    logic [CNT_W-1:0]      r_llc;
    logic [RT_W-1:0]       r_retries;
    logic [RC_W-1:0]       r_rst_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [ST_W-1:0]       r_st_cnt;
    logic [SG_W-1:0]       r_sg_cnt;
    logic                  w_lock_lost;

    assign w_lock_lost = ~r_locked_s;

    // The counter leaves reset at 0 so the reset cycle itself precedes the
    // RST_CYCLES hold; every later entry into RESET_PLL starts the count at 1.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state    <= S_RESET_PLL;
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
            r_pll_rst  <= 1'b1;
            r_rst_out  <= '1;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
            r_llc      <= '0;
            r_retries  <= '0;
            r_rst_cnt  <= '0;
            r_to_cnt   <= '0;
            r_st_cnt   <= '0;
            r_sg_cnt   <= '0;
        end else begin
            r_sync1    <= locked;
            r_locked_s <= r_sync1;
            case (r_state)
                S_RESET_PLL: begin
                    if (force_relock) begin
                        r_rst_cnt <= RC_FIRST;
                    end else if (r_rst_cnt == RC_LAST) begin
                        r_state   <= S_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_to_cnt  <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (force_relock) begin
                        r_state   <= S_RESET_PLL;
                        r_pll_rst <= 1'b1;
                        r_rst_cnt <= RC_FIRST;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_pll_rst <= 1'b1;
                        if (r_retries < RT_MAX) begin
                            r_retries <= r_retries + 1'b1;
                            r_state   <= S_RESET_PLL;
                            r_rst_cnt <= RC_FIRST;
                        end else begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end
                    end else if (r_state == S_WAIT_LOCK) begin
                        if (r_locked_s) begin
                            r_state  <= S_STABLE;
                            r_st_cnt <= '0;
                        end
                    end else if (w_lock_lost) begin
                        r_state <= S_WAIT_LOCK;
                    end else if (r_st_cnt == ST_LAST) begin
                        r_state   <= S_RELEASE;
                        r_rst_out <= r_rst_out << 1;
                        r_sg_cnt  <= '0;
                    end else begin
                        r_st_cnt <= r_st_cnt + 1'b1;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (w_lock_lost || force_relock) begin
                        r_state   <= S_RESET_PLL;
                        r_pll_rst <= 1'b1;
                        r_rst_out <= '1;
                        r_ready   <= 1'b0;
                        r_rst_cnt <= RC_FIRST;
                        if (w_lock_lost && (r_llc != '1)) begin
                            r_llc <= r_llc + 1'b1;
                        end
                    end else if (r_state == S_RELEASE) begin
                        // Released bits shift out from bit 0 upward; all-zero means every domain is out.
                        if (r_rst_out == '0) begin
                            r_state   <= S_RUN;
                            r_ready   <= 1'b1;
                            r_retries <= '0;
                        end else if (r_sg_cnt == SG_LAST) begin
                            r_rst_out <= r_rst_out << 1;
                            r_sg_cnt  <= '0;
                        end else begin
                            r_sg_cnt <= r_sg_cnt + 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    if (force_relock) begin
                        r_state   <= S_RESET_PLL;
                        r_fault   <= 1'b0;
                        r_retries <= '0;
                        r_rst_cnt <= RC_FIRST;
                    end
                end
                default: begin
                    r_state   <= S_RESET_PLL;
                    r_pll_rst <= 1'b1;
                    r_rst_out <= '1;
                    r_ready   <= 1'b0;
                    r_rst_cnt <= RC_FIRST;
                end
            endcase
        end
    end

    assign pll_rst         = r_pll_rst;
    assign rst_out         = r_rst_out;
    assign ready           = r_ready;
    assign fault           = r_fault;
    assign lock_loss_count = r_llc;

endmodule

// File: tb/tb_pll_lock_manager.sv
// tb/tb_pll_lock_manager.sv - scoreboard bench for pll_lock_manager with a timestamp-based reference model
module tb_pll_lock_manager;
    localparam int N    = 3;
    localparam int RSTC = 4;
    localparam int TO   = 100;
    localparam int STB  = 10;
    localparam int STG  = 3;
    localparam int MR   = 2;
    localparam int CW   = 4;
    localparam int OW   = 1 + N + 1 + 1 + CW;

    localparam int M_HOLD    = 0;
    localparam int M_LOCKING = 1;
    localparam int M_RELEASE = 2;
    localparam int M_FAULT   = 3;

    logic          refclk = 1'b0;
    logic          rst;
    logic          locked;
    logic          force_relock;
    logic          pll_rst;
    logic [N-1:0]  rst_out;
    logic          ready;
    logic          fault;
    logic [CW-1:0] lock_loss_count;

    typedef struct {
        int            edge_no;
        logic [OW-1:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fails  = 0;
    int  edge_cnt = 0;

    int            m_phase = M_HOLD;
    int            m_hold_end = 0;
    int            m_wait_entry = 0;
    int            m_stable_since = -1;
    int            m_rel_start = 0;
    int            m_retries = 0;
    int            m_llc = 0;
    logic          m_d1 = 1'b0;
    logic          m_d2 = 1'b0;
    logic [OW-1:0] m_prev = 'x;

    pll_lock_manager #(
        .NUM_CLOCKS(N), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB),
        .STAGGER(STG), .MAX_RETRIES(MR), .CNT_W(CW)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .force_relock(force_relock),
        .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready), .fault(fault),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) edge_cnt <= edge_cnt + 1;

    function automatic logic [OW-1:0] dut_out();
        return {pll_rst, rst_out, ready, fault, lock_loss_count};
    endfunction

    // Outputs after edge k are derived from timestamps of the current phase.
    task automatic model_edge(input int k, input logic lk, input logic f, input logic r);
        logic          ls;
        logic [N-1:0]  ro;
        logic          rdy;
        logic          prst;
        logic          flt;
        logic [OW-1:0] v;
        int            run_at;
        ls = m_d2;
        run_at = m_rel_start + (N - 1) * STG + 1;
        if (r) begin
            m_phase = M_HOLD; m_hold_end = k + RSTC + 1; m_retries = 0; m_llc = 0;
        end else begin
            case (m_phase)
                M_HOLD: begin
                    if (f) m_hold_end = k + RSTC;
                    else if (k == m_hold_end) begin
                        m_phase = M_LOCKING; m_wait_entry = k; m_stable_since = -1;
                    end
                end
                M_LOCKING: begin
                    if (f) begin
                        m_phase = M_HOLD; m_hold_end = k + RSTC;
                    end else if (k - m_wait_entry == TO) begin
                        if (m_retries < MR) begin
                            m_retries++; m_phase = M_HOLD; m_hold_end = k + RSTC;
                        end else m_phase = M_FAULT;
                    end else if (m_stable_since < 0) begin
                        if (ls) m_stable_since = k;
                    end else if (!ls) m_stable_since = -1;
                    else if (k - m_stable_since == STB) begin
                        m_phase = M_RELEASE; m_rel_start = k;
                    end
                end
                M_RELEASE: begin
                    if (!ls || f) begin
                        m_phase = M_HOLD; m_hold_end = k + RSTC;
                        if (!ls && m_llc < (1 << CW) - 1) m_llc++;
                    end else if (k >= run_at) m_retries = 0;
                end
                default: begin
                    if (f) begin
                        m_phase = M_HOLD; m_hold_end = k + RSTC; m_retries = 0;
                    end
                end
            endcase
        end
        if (r) begin m_d1 = 1'b0; m_d2 = 1'b0; end
        else begin m_d2 = m_d1; m_d1 = lk; end

        ro = '1; rdy = 1'b0; prst = 1'b0; flt = 1'b0;
        run_at = m_rel_start + (N - 1) * STG + 1;
        if (m_phase == M_HOLD) prst = 1'b1;
        if (m_phase == M_FAULT) begin prst = 1'b1; flt = 1'b1; end
        if (m_phase == M_RELEASE) begin
            for (int i = 0; i < N; i++) ro[i] = (k < m_rel_start + i * STG);
            rdy = (k >= run_at);
        end
        v = {prst, ro, rdy, flt, CW'(m_llc)};
        if (v !== m_prev) begin
            exp_q.push_back('{k, v});
            m_prev = v;
        end
    endtask

    task automatic step(input logic lk, input logic f, input logic r);
        locked = lk; force_relock = f; rst = r;
        model_edge(edge_cnt, lk, f, r);
        @(negedge refclk);
    endtask

    task automatic run(input int n, input logic lk);
        repeat (n) step(lk, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_cnt - 1);
        end
    endtask

    initial begin : monitor
        logic [OW-1:0] prev;
        logic [OW-1:0] cur;
        ev_t           e;
        prev = 'x;
        forever begin
            @(posedge refclk);
            #1;
            cur = dut_out();
            if (cur !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_change: got %h at edge %0d, expected no change", cur, edge_cnt - 1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_no != edge_cnt - 1 || e.val !== cur) begin
                        n_fails++;
                        $display("FAIL output_event: got %h at edge %0d, expected %h at edge %0d",
                                 cur, edge_cnt - 1, e.val, e.edge_no);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        int   len;
        logic lv;
        // clean start
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run(4, 1'b1);  chk("clean_pll_rst_c3", int'(pll_rst), 1);
        run(1, 1'b1);  chk("clean_pll_rst_c4", int'(pll_rst), 0);
        run(10, 1'b1); chk("clean_rst_out_c14", int'(rst_out), 7);
        run(1, 1'b1);  chk("clean_rst_out_c15", int'(rst_out), 6);
        run(3, 1'b1);  chk("clean_rst_out_c18", int'(rst_out), 4);
        run(2, 1'b1);  chk("clean_ready_c20", int'(ready), 0);
        run(1, 1'b1);  chk("clean_rst_out_c21", int'(rst_out), 0);
        chk("clean_ready_c21", int'(ready), 0);
        run(1, 1'b1);  chk("clean_ready_c22", int'(ready), 1);
        chk("clean_fault", int'(fault), 0);

        // no lock: two retries then FAULT, then force_relock
        step(1'b0, 1'b0, 1'b1);
        run(104, 1'b0); chk("nolock_pll_rst_c103", int'(pll_rst), 0);
        run(1, 1'b0);   chk("nolock_pll_rst_c104", int'(pll_rst), 1);
        run(103, 1'b0); chk("nolock_pll_rst_c207", int'(pll_rst), 0);
        run(1, 1'b0);   chk("nolock_pll_rst_c208", int'(pll_rst), 1);
        run(103, 1'b0); chk("nolock_fault_c311", int'(fault), 0);
        run(1, 1'b0);   chk("nolock_fault_c312", int'(fault), 1);
        chk("nolock_pll_rst_c312", int'(pll_rst), 1);
        run(20, 1'b0);  chk("fault_held", int'(fault), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("force_clears_fault", int'(fault), 0);
        chk("force_pll_rst_0", int'(pll_rst), 1);
        run(3, 1'b0);   chk("force_pll_rst_3", int'(pll_rst), 1);
        run(1, 1'b0);   chk("force_pll_rst_4", int'(pll_rst), 0);

        // glitch during STABLE
        step(1'b1, 1'b0, 1'b1);
        run(8, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run(6, 1'b1);  chk("glitch_no_release_c15", int'(rst_out), 7);
        run(6, 1'b1);  chk("glitch_no_release_c20", int'(rst_out), 7);
        run(1, 1'b1);  chk("glitch_release_c21", int'(rst_out), 6);
        chk("glitch_count", int'(lock_loss_count), 0);
        run(10, 1'b1); chk("glitch_run_ready", int'(ready), 1);

        // single-cycle lock loss from RUN
        step(1'b0, 1'b0, 1'b0);
        run(1, 1'b1);  chk("loss_no_react_yet", int'(rst_out), 0);
        run(1, 1'b1);  chk("loss_rst_out", int'(rst_out), 7);
        chk("loss_ready", int'(ready), 0);
        chk("loss_pll_rst", int'(pll_rst), 1);
        chk("loss_count", int'(lock_loss_count), 1);
        run(30, 1'b1); chk("loss_rerelease_ready", int'(ready), 1);

        // saturation: 20 losses in total
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 1'b0, 1'b0);
            run(30, 1'b1);
        end
        chk("loss_count_saturated", int'(lock_loss_count), 15);

        // rst in the middle of RELEASE
        step(1'b0, 1'b0, 1'b0);
        run(20, 1'b1); chk("mid_release_pre", int'(rst_out), 4);
        step(1'b1, 1'b0, 1'b1);
        chk("mid_release_rst_out", int'(rst_out), 7);
        chk("mid_release_pll_rst", int'(pll_rst), 1);
        chk("mid_release_ready", int'(ready), 0);
        chk("mid_release_count", int'(lock_loss_count), 0);

        // randomized segments against the model
        for (int s = 0; s < 120; s++) begin
            len = $urandom_range(1, 60);
            lv  = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < len; j++)
                step(lv, ($urandom_range(0, 99) == 0), ($urandom_range(0, 999) == 0));
        end

        run(5, 1'b1);
        chk("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
